cobra_prog_loader: RTL and testbench

// - Writer side of the CYBERcobra instruction memory: receives a framed byte stream and writes
//   32-bit instruction words into a writable instruction memory starting at byte address 0.
// - Holds the core in reset while loading; releases it only after a frame passes its checksum.
// - Sits between the byte-stream source (UART RX / debug link) and the imem write port plus the core rst_i.

---
 rtl/cobra_loader_pkg.sv | 18 +
 rtl/cobra_word_packer.sv | 44 ++++
 rtl/cobra_prog_loader.sv | 152 +++++++++++++++
 tb/tb_cobra_prog_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cobra_loader_pkg.sv
// Shared types and defaults for the CYBERcobra program loader.
// The state encoding is fixed so that waveforms and debug taps stay readable across revisions.
package cobra_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned MEM_WORDS_DEF = 1024;

endpackage

// File: rtl/cobra_word_packer.sv
// Collects four little-endian bytes into one 32-bit word.
// word_valid_o/word_o are combinational on the 4th byte, so the caller can register the write.
module cobra_word_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;

  // Earlier bytes sit in shift_q with byte 0 ending up in the low lane once byte 3 arrives.
  assign word_valid_o = byte_valid_i && (idx_q == 2'd3);
  assign word_o       = {byte_i, shift_q};

  // NOTE: every variable gets a default first, so no path through the block infers a latch.
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear_i) begin
      idx_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid_i) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {byte_i, shift_q[23:8]};
    end
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values, whatever the order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/cobra_prog_loader.sv
// Framed byte-stream loader for the CYBERcobra instruction memory.
// Keeps the core in reset until a complete frame has passed its XOR checksum.
module cobra_prog_loader
  import cobra_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [15:0] MAX_LEN = 16'(MEM_WORDS);

  loader_state_t state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [7:0]    csum_q, csum_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          core_rst_q, core_rst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept;
  logic          start_frame;
  logic [15:0]   len_new;
  logic          word_valid;
  logic [31:0]   word;

  // The write cycle blocks input so a byte can never race the imem write of the previous word.
  assign rx_ready_o = rst_ni && !mem_we_q;
  assign accept     = rx_valid_i && rx_ready_o;
  assign len_new    = {rx_data_i, len_q[7:0]};

  cobra_word_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (start_frame),
    .byte_valid_i (accept && (state_q == DATA)),
    .byte_i       (rx_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    start_frame = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (accept && (rx_data_i == SYNC_BYTE)) begin
          state_d     = LEN_LO;
          start_frame = 1'b1;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data_i;
          csum_d     = csum_q ^ rx_data_i;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d  = len_new;
          csum_d = csum_q ^ rx_data_i;
          if (len_new > MAX_LEN)      state_d = ERR;
          else if (len_new == 16'd0)  state_d = CSUM;
          else                        state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data_i;
          if (word_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {14'b0, word_idx_q, 2'b00};
            mem_wdata_d = word;
            word_idx_d  = word_idx_q + 16'd1;
            if (word_idx_q == len_q - 16'd1) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) state_d = (rx_data_i == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      len_d      = 16'd0;
      word_idx_d = 16'd0;
      csum_d     = 8'd0;
    end

    // Status flags follow the next state, so they are registered and change exactly on entry.
    core_rst_d = (state_d != DONE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      len_q       <= 16'd0;
      word_idx_q  <= 16'd0;
      csum_q      <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign core_rst_o  = core_rst_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_cobra_prog_loader.sv
// Directed bench for cobra_prog_loader: cycle-by-cycle vector table plus a few multi-cycle sequences.
module tb_cobra_prog_loader;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        core_rst_o;
  logic        done_o;
  logic        err_o;

  always #5 clk = ~clk;

  cobra_prog_loader dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .core_rst_o  (core_rst_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  // flags = {mem_we, rx_ready, core_rst, done, err}
  localparam logic [4:0] F_RST  = 5'b00100;
  localparam logic [4:0] F_RUN  = 5'b01100;
  localparam logic [4:0] F_WR   = 5'b10100;
  localparam logic [4:0] F_DONE = 5'b01010;
  localparam logic [4:0] F_ERR  = 5'b01101;

  logic [4:0] flags;
  assign flags = {mem_we_o, rx_ready_o, core_rst_o, done_o, err_o};

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [7:0]  data;
    logic [4:0]  flags;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];

  logic [7:0] rand_frame [0:14] = '{8'hA5, 8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                                    8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hA5, 8'h00, 8'h00, 8'h00};
  logic [7:0] good_frame [0:11] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                    8'h37, 8'h01, 8'h00, 8'h00, 8'h27};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic [4:0] f, input logic [31:0] a, input logic [31:0] w);
    vec_t t;
    t.rst_n = r; t.valid = v; t.data = d; t.flags = f; t.addr = a; t.wdata = w;
    vecs.push_back(t);
  endtask

  // Offers one byte, optionally after random idle cycles, until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    logic acc;
    int   tries;
    repeat ($urandom_range(0, max_gap)) begin
      @(negedge clk);
      rx_valid_i = 1'b0;
    end
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 8) begin
      @(negedge clk);
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      acc        = rx_ready_o;
      if (mem_we_o) check("no_accept_during_write", {31'b0, acc}, 32'd0);
      @(posedge clk);
      tries++;
    end
    #1 rx_valid_i = 1'b0;
    if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (mem_we_o === 1'b1) begin
      wlog_addr.push_back(mem_addr_o);
      wlog_data.push_back(mem_wdata_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "time limit reached");
  end

  initial begin
    logic [7:0]  csum;
    logic [31:0] exp_addr [0:2];
    logic [31:0] exp_data [0:2];

    // Reset, then good 2-word frame, then a byte ignored in DONE.
    add(0, 0, 8'h00, F_RST, 32'd0, 32'd0);
    add(1, 1, 8'hA5, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h02, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h00, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h13, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h00, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h00, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h00, F_WR,  32'd0, 32'h00000013);
    add(1, 0, 8'h00, F_RUN, 32'd0, 32'h00000013);
    add(1, 1, 8'h37, F_RUN, 32'd0, 32'h00000013);
    add(1, 1, 8'h01, F_RUN, 32'd0, 32'h00000013);
    add(1, 1, 8'h00, F_RUN, 32'd0, 32'h00000013);
    add(1, 1, 8'h00, F_WR,  32'd4, 32'h00000137);
    add(1, 0, 8'h00, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h27, F_DONE, 32'd4, 32'h00000137);
    add(1, 1, 8'h11, F_DONE, 32'd4, 32'h00000137);
    // Same frame with a bad checksum: words still written, ERR.
    add(1, 1, 8'hA5, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h02, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h00, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h13, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h00, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h00, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h00, F_WR,  32'd0, 32'h00000013);
    add(1, 0, 8'h00, F_RUN, 32'd0, 32'h00000013);
    add(1, 1, 8'h37, F_RUN, 32'd0, 32'h00000013);
    add(1, 1, 8'h01, F_RUN, 32'd0, 32'h00000013);
    add(1, 1, 8'h00, F_RUN, 32'd0, 32'h00000013);
    add(1, 1, 8'h00, F_WR,  32'd4, 32'h00000137);
    add(1, 0, 8'h00, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h26, F_ERR, 32'd4, 32'h00000137);
    // N = 1025 rejected right after LEN_HI; a stray byte stays in ERR.
    add(1, 1, 8'hA5, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h01, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h04, F_ERR, 32'd4, 32'h00000137);
    add(1, 1, 8'h00, F_ERR, 32'd4, 32'h00000137);
    // Zero-length frame.
    add(1, 1, 8'hA5, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h00, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h00, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h00, F_DONE, 32'd4, 32'h00000137);
    // N = 1024 is still legal, then reset aborts it.
    add(1, 1, 8'hA5, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h00, F_RUN, 32'd4, 32'h00000137);
    add(1, 1, 8'h04, F_RUN, 32'd4, 32'h00000137);
    add(0, 0, 8'h00, F_RST, 32'd0, 32'd0);
    // Junk dropped in IDLE, then empty frame.
    add(1, 1, 8'h00, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'hFF, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h11, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'hA5, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h00, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h00, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h00, F_DONE, 32'd0, 32'd0);
    // Sync bytes inside the payload are data.
    add(1, 1, 8'hA5, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h01, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'h00, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'hA5, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'hA5, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'hA5, F_RUN, 32'd0, 32'd0);
    add(1, 1, 8'hA5, F_WR,  32'd0, 32'hA5A5A5A5);
    add(1, 0, 8'h00, F_RUN, 32'd0, 32'hA5A5A5A5);
    add(1, 1, 8'h01, F_DONE, 32'd0, 32'hA5A5A5A5);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_ni     = vecs[i].rst_n;
      rx_valid_i = vecs[i].valid;
      rx_data_i  = vecs[i].data;
      @(posedge clk);
      #1;
      check($sformatf("v%0d flags", i), {27'b0, flags}, {27'b0, vecs[i].flags});
      check($sformatf("v%0d addr", i), mem_addr_o, vecs[i].addr);
      check($sformatf("v%0d wdata", i), mem_wdata_o, vecs[i].wdata);
    end
    @(negedge clk);
    rx_valid_i = 1'b0;

    // 3-word frame with random valid gaps.
    wlog_addr.delete();
    wlog_data.delete();
    csum = 8'h00;
    for (int i = 1; i < 15; i++) csum ^= rand_frame[i];
    for (int i = 0; i < 15; i++) send_byte(rand_frame[i], 2);
    send_byte(csum, 2);
    repeat (2) @(posedge clk);
    #1;
    exp_addr = '{32'd0, 32'd4, 32'd8};
    exp_data = '{32'h11223344, 32'hDEADBEEF, 32'h000000A5};
    check("gap_done", {31'b0, done_o}, 32'd1);
    check("gap_core_rst", {31'b0, core_rst_o}, 32'd0);
    check("gap_write_count", 32'(wlog_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wlog_addr.size()) begin
        check($sformatf("gap_addr%0d", i), wlog_addr[i], exp_addr[i]);
        check($sformatf("gap_data%0d", i), wlog_data[i], exp_data[i]);
      end
    end

    // Asynchronous reset after two data bytes, then a clean reload.
    wlog_addr.delete();
    wlog_data.delete();
    for (int i = 0; i < 5; i++) send_byte(good_frame[i], 0);
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_flags", {27'b0, flags}, {27'b0, F_RST});
    check("async_rst_addr", mem_addr_o, 32'd0);
    check("async_rst_wdata", mem_wdata_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    check("partial_word_not_written", 32'(wlog_addr.size()), 32'd0);
    for (int i = 0; i < 12; i++) send_byte(good_frame[i], 0);
    repeat (2) @(posedge clk);
    #1;
    exp_addr = '{32'd0, 32'd4, 32'd0};
    exp_data = '{32'h00000013, 32'h00000137, 32'd0};
    check("reload_done", {31'b0, done_o}, 32'd1);
    check("reload_core_rst", {31'b0, core_rst_o}, 32'd0);
    check("reload_write_count", 32'(wlog_addr.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      if (i < wlog_addr.size()) begin
        check($sformatf("reload_addr%0d", i), wlog_addr[i], exp_addr[i]);
        check($sformatf("reload_data%0d", i), wlog_data[i], exp_data[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
